// File: rtl/mul_seq_pkg.sv
// Shared constants and state encoding for the iterative signed multiplier.
//   WIDTH : default operand/result width (two's complement)
//   ITER  : number of shift-add iterations (one per operand bit)
//   CNT_W : width of the iteration counter
//   state_t : IDLE=2'b00, RUN=2'b01, FIN=2'b10 (2'b11 is unused and recovers to IDLE)
package mul_seq_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned ITER  = WIDTH;
   localparam int unsigned CNT_W = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the CPU control unit and the multiplier.
//   start   : request pulse, sampled only while the multiplier is idle
//   data1   : multiplicand (two's complement), sampled with start
//   data2   : multiplier (two's complement), sampled with start
//   busy    : high while an operation is in flight
//   done    : one-cycle pulse, mul_out/ovf freshly updated
//   mul_out : low WIDTH bits of the signed product, held until the next done
//   ovf     : full product does not fit in WIDTH signed bits, held with mul_out
// master = requester (CPU side), slave = multiplier.
interface mul_sequencer_if #(
   parameter int unsigned WIDTH = mul_seq_pkg::WIDTH
);

   logic             start;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] mul_out;
   logic             ovf;

   modport master (
      output start, data1, data2,
      input  busy, done, mul_out, ovf
   );

   modport slave (
      input  start, data1, data2,
      output busy, done, mul_out, ovf
   );

endinterface

// File: rtl/mul_seq_abs.sv
// Combinational conditional two's-complement negate.
//   in  : N-bit value
//   neg : 1 -> out = -in (~in + 1), 0 -> out = in
//   out : N-bit result
// Used to take operand magnitudes (neg = sign bit) and to apply the product sign.
module mul_seq_abs #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] in,
   input  logic         neg,
   output logic [N-1:0] out
);

   assign out = neg ? (~in + N'(1)) : in;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle signed WIDTH x WIDTH multiplier for the ALU MUL path.
// Latches operand magnitudes and the product sign on start, runs WIDTH shift-add
// iterations over the magnitudes, then applies the sign and registers the low
// WIDTH bits of the product together with an overflow flag.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset; discards any in-flight operation
//   bus     : mul_sequencer_if slave (start/data1/data2 in; busy/done/mul_out/ovf out)
module mul_sequencer
   import mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = mul_seq_pkg::WIDTH
) (
   input  logic           clk,
   input  logic           reset_n,
   mul_sequencer_if.slave bus
);

   localparam int unsigned N_ITER = WIDTH;
   localparam int unsigned ACC_W  = 2 * WIDTH;
   localparam int unsigned C_W    = $clog2(N_ITER + 1);

   state_t             state_q;
   state_t             state_d;

   logic               sign_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   mult_q;
   logic [ACC_W-1:0]   acc_q;
   logic [C_W-1:0]     cnt_q;

   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   mul_out_q;
   logic               ovf_q;

   logic               load_c;
   logic               step_c;
   logic               fin_c;
   logic [WIDTH-1:0]   mag1_c;
   logic [WIDTH-1:0]   mag2_c;
   logic [ACC_W-1:0]   addend_c;
   logic [ACC_W-1:0]   prod_c;
   logic [WIDTH:0]     prod_hi_c;
   logic               ovf_c;

   // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value.
   mul_seq_abs #(.N(WIDTH)) u_abs1 (
      .in  (bus.data1),
      .neg (bus.data1[WIDTH-1]),
      .out (mag1_c)
   );

   mul_seq_abs #(.N(WIDTH)) u_abs2 (
      .in  (bus.data2),
      .neg (bus.data2[WIDTH-1]),
      .out (mag2_c)
   );

   // Signed product at full width; a zero magnitude stays zero when negated.
   mul_seq_abs #(.N(ACC_W)) u_abs_prod (
      .in  (acc_q),
      .neg (sign_q),
      .out (prod_c)
   );

   // Next state and per-cycle datapath controls.
   always_comb begin
      state_d = state_q;
      load_c  = 1'b0;
      step_c  = 1'b0;
      fin_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               load_c  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step_c = 1'b1;
            // Last iteration runs on this edge, so leave RUN together with it.
            if (cnt_q == C_W'(N_ITER - 1)) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            fin_c   = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign addend_c = ACC_W'(mcand_q) << cnt_q;

   // The magnitude never exceeds 2^(2*WIDTH-2), so the full-width product cannot wrap;
   // it fits in WIDTH signed bits exactly when bits [ACC_W-1:WIDTH-1] are all equal.
   assign prod_hi_c = prod_c[ACC_W-1:WIDTH-1];
   assign ovf_c     = !((&prod_hi_c) || (~|prod_hi_c));

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, accumulator and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sign_q  <= 1'b0;
         mcand_q <= '0;
         mult_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (load_c) begin
         sign_q  <= bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1];
         mcand_q <= mag1_c;
         mult_q  <= mag2_c;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (step_c) begin
         if (mult_q[0]) begin
            acc_q <= acc_q + addend_c;
         end
         mult_q <= mult_q >> 1;
         cnt_q  <= cnt_q + C_W'(1);
      end
   end

   // Registered outputs; result holds between done pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mul_out_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         busy_q <= (state_d != ST_IDLE);
         done_q <= fin_c;
         if (fin_c) begin
            mul_out_q <= prod_c[WIDTH-1:0];
            ovf_q     <= ovf_c;
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.mul_out = mul_out_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed cases, busy-start rejection,
// back-to-back issue, mid-operation reset, and random operands against an
// integer-arithmetic reference model.
module tb_mul_sequencer;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   mul_sequencer_if #(.WIDTH(8)) bus ();

   mul_sequencer #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: true signed product, low 8 bits and representability in 8 signed bits.
   task automatic ref_mul(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic o);
      int sa;
      int sb;
      int p;
      sa = int'($signed(a));
      sb = int'($signed(b));
      p  = sa * sb;
      r  = 8'(p);
      o  = (p > 127) || (p < -128);
   endtask

   // Issue one operation (start is driven in whatever cycle we are in), scramble
   // the operand inputs afterwards, optionally poke start while busy, then check
   // latency, busy and the result.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit inject);
      logic [7:0] er;
      logic       eo;
      int         n;
      bit         seen;
      ref_mul(a, b, er, eo);
      bus.start = 1'b1;
      bus.data1 = a;
      bus.data2 = b;
      step();
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      check("done_not_consecutive", 32'(bus.done), 32'd0);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         if (inject && n >= 2 && n <= 4) begin
            bus.start = 1'b1;
            bus.data1 = 8'd7;
            bus.data2 = 8'd7;
         end else begin
            bus.start = 1'b0;
            bus.data1 = 8'($urandom);
            bus.data2 = 8'($urandom);
         end
         step();
         n++;
         if (bus.done) seen = 1'b1;
      end
      bus.start = 1'b0;
      check("latency", 32'(n), 32'd9);
      check("busy_at_done", 32'(bus.busy), 32'd0);
      check("mul_out", 32'(bus.mul_out), 32'(er));
      check("ovf", 32'(bus.ovf), 32'(eo));
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      n_tests   = 0;
      n_fail    = 0;
      clk       = 1'b0;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.data1 = '0;
      bus.data2 = '0;

      // Reset state.
      step();
      step();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_mul_out", 32'(bus.mul_out), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      reset_n = 1'b1;
      step();
      step();
      check("idle_done", 32'(bus.done), 32'd0);

      // Directed cases.
      run_op(8'd5, 8'd3, 1'b0);
      step();
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("hold_mul_out", 32'(bus.mul_out), 32'h0F);
      run_op(8'hFC, 8'd6, 1'b0);
      run_op(8'h80, 8'd1, 1'b0);
      run_op(8'h80, 8'hFF, 1'b0);
      run_op(8'd16, 8'd16, 1'b0);
      run_op(8'hF9, 8'd0, 1'b0);
      run_op(8'd3, 8'hFD, 1'b0);
      run_op(8'h80, 8'h80, 1'b0);
      run_op(8'hF5, 8'd11, 1'b0);

      // Start while busy is ignored and not queued.
      run_op(8'd2, 8'd3, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step();
         check("no_extra_done", 32'(bus.done), 32'd0);
      end
      check("busy_start_ignored", 32'(bus.mul_out), 32'h06);

      // Back-to-back: second start lands in the done cycle.
      run_op(8'd2, 8'd3, 1'b0);
      run_op(8'd7, 8'd7, 1'b0);

      // Reset in the middle of a 9*9 run.
      bus.start = 1'b1;
      bus.data1 = 8'd9;
      bus.data2 = 8'd9;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(bus.busy), 32'd0);
      check("async_rst_done", 32'(bus.done), 32'd0);
      check("async_rst_mul_out", 32'(bus.mul_out), 32'd0);
      check("async_rst_ovf", 32'(bus.ovf), 32'd0);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         check("no_done_after_rst", 32'(bus.done), 32'd0);
      end
      check("idle_after_rst", 32'(bus.busy), 32'd0);
      run_op(8'd2, 8'd2, 1'b0);

      // Random operands, mixed issue spacing.
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if (($urandom % 8) == 0) a = 8'h80;
         if (($urandom % 8) == 0) b = 8'h00;
         run_op(a, b, 1'($urandom % 2));
         if (($urandom % 2) == 0) step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
